// File: rtl/msrh_snoop_unit.sv
// Snoop unit: resolves one L2 snoop into a line response by probing L1D (with
// conflict retries) and, when MSRH_SNOOP_STQ_MERGE_EN is defined, the store queue.

package msrh_conf_pkg;
    localparam int DCACHE_DATA_W = 128;
endpackage

package msrh_lsu_pkg;
    typedef enum logic [1:0] {
        STATUS_NONE         = 2'd0,
        STATUS_HIT          = 2'd1,
        STATUS_MISS         = 2'd2,
        STATUS_L1D_CONFLICT = 2'd3
    } status_t;
endpackage

module msrh_snoop_unit
    import msrh_lsu_pkg::*;
#(
    parameter int PADDR_W         = 56,
    parameter int DCACHE_DATA_W   = msrh_conf_pkg::DCACHE_DATA_W,
    parameter int DCACHE_DATA_B_W = DCACHE_DATA_W / 8,
    parameter int MAX_RETRY       = 3
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,

    input  logic                       i_snoop_req_valid,
    output logic                       o_snoop_req_ready,
    input  logic [PADDR_W-1:0]         i_snoop_req_paddr,

    output logic                       o_l1d_req_s0_valid,
    output logic [PADDR_W-1:0]         o_l1d_req_s0_paddr,
    input  logic                       i_l1d_resp_s1_valid,
    input  status_t                    i_l1d_resp_s1_status,
    input  logic [DCACHE_DATA_W-1:0]   i_l1d_resp_s1_data,

    output logic                       o_stq_req_s0_valid,
    output logic [PADDR_W-1:0]         o_stq_req_s0_paddr,
    input  logic                       i_stq_resp_s1_valid,
    input  logic [DCACHE_DATA_B_W-1:0] i_stq_resp_s1_be,
    input  logic [DCACHE_DATA_W-1:0]   i_stq_resp_s1_data,

    output logic                       o_snoop_resp_valid,
    input  logic                       i_snoop_resp_ready,
    output status_t                    o_snoop_resp_status,
    output logic [DCACHE_DATA_B_W-1:0] o_snoop_resp_be,
    output logic [DCACHE_DATA_W-1:0]   o_snoop_resp_data
);

    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    localparam logic [PADDR_W-1:0] LINE_MASK = PADDR_W'(DCACHE_DATA_B_W - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                     state_q, state_d;
    logic [PADDR_W-1:0]         paddr_q, paddr_d;
    logic                       l1d_done_q, l1d_done_d;
    logic                       stq_done_q, stq_done_d;
    logic [RTY_W-1:0]           retry_q, retry_d;
    logic                       cache_hit_q, cache_hit_d;
    logic [DCACHE_DATA_W-1:0]   cache_data_q, cache_data_d;
    logic [DCACHE_DATA_B_W-1:0] stq_be_q, stq_be_d;
    logic [DCACHE_DATA_W-1:0]   stq_data_q, stq_data_d;
    status_t                    status_q, status_d;
    logic                       wait_first_q, wait_first_d;
    logic                       l1d_req_q, l1d_req_d;
    logic                       stq_req_q, stq_req_d;
    logic                       stq_cap;
    logic [DCACHE_DATA_W-1:0]   merged_data;

`ifdef MSRH_SNOOP_STQ_MERGE_EN
    localparam bit STQ_EN = 1'b1;
    // The STQ answer may land during a conflict re-issue, so REQ also captures.
    assign stq_cap = i_stq_resp_s1_valid & ~stq_done_q &
                     ((state_q == REQ) | (state_q == WAIT));
`else
    localparam bit STQ_EN = 1'b0;
    logic unused_stq;
    assign unused_stq = ^{i_stq_resp_s1_valid, i_stq_resp_s1_be, i_stq_resp_s1_data};
    assign stq_cap    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        paddr_d      = paddr_q;
        l1d_done_d   = l1d_done_q;
        stq_done_d   = stq_done_q;
        retry_d      = retry_q;
        cache_hit_d  = cache_hit_q;
        cache_data_d = cache_data_q;
        stq_be_d     = stq_be_q;
        stq_data_d   = stq_data_q;
        status_d     = status_q;
        wait_first_d = 1'b0;
        l1d_req_d    = 1'b0;
        stq_req_d    = 1'b0;

        if (stq_cap) begin
            stq_be_d   = i_stq_resp_s1_be;
            stq_data_d = i_stq_resp_s1_data;
            stq_done_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (i_snoop_req_valid) begin
                    paddr_d      = i_snoop_req_paddr & ~LINE_MASK;
                    l1d_done_d   = 1'b0;
                    stq_done_d   = ~STQ_EN;
                    retry_d      = '0;
                    cache_hit_d  = 1'b0;
                    cache_data_d = '0;
                    stq_be_d     = '0;
                    stq_data_d   = '0;
                    status_d     = STATUS_NONE;
                    l1d_req_d    = 1'b1;
                    stq_req_d    = STQ_EN;
                    state_d      = REQ;
                end
            end
            REQ: begin
                wait_first_d = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                // L1D answers exactly one cycle after s0; later pulses are strays.
                if (wait_first_q && i_l1d_resp_s1_valid) begin
                    case (i_l1d_resp_s1_status)
                        STATUS_HIT: begin
                            cache_hit_d  = 1'b1;
                            cache_data_d = i_l1d_resp_s1_data;
                            l1d_done_d   = 1'b1;
                            status_d     = STATUS_HIT;
                        end
                        STATUS_MISS: begin
                            l1d_done_d = 1'b1;
                            status_d   = STATUS_MISS;
                        end
                        STATUS_L1D_CONFLICT: begin
                            if (retry_q < RTY_W'(MAX_RETRY)) begin
                                retry_d   = retry_q + RTY_W'(1);
                                l1d_req_d = 1'b1;
                                state_d   = REQ;
                            end else begin
                                l1d_done_d = 1'b1;
                                status_d   = STATUS_L1D_CONFLICT;
                            end
                        end
                        default: ;
                    endcase
                end
                if (l1d_done_d && stq_done_d) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (i_snoop_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            paddr_q      <= '0;
            l1d_done_q   <= 1'b0;
            stq_done_q   <= 1'b0;
            retry_q      <= '0;
            cache_hit_q  <= 1'b0;
            cache_data_q <= '0;
            stq_be_q     <= '0;
            stq_data_q   <= '0;
            status_q     <= STATUS_NONE;
            wait_first_q <= 1'b0;
            l1d_req_q    <= 1'b0;
            stq_req_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            paddr_q      <= paddr_d;
            l1d_done_q   <= l1d_done_d;
            stq_done_q   <= stq_done_d;
            retry_q      <= retry_d;
            cache_hit_q  <= cache_hit_d;
            cache_data_q <= cache_data_d;
            stq_be_q     <= stq_be_d;
            stq_data_q   <= stq_data_d;
            status_q     <= status_d;
            wait_first_q <= wait_first_d;
            l1d_req_q    <= l1d_req_d;
            stq_req_q    <= stq_req_d;
        end
    end

    // Store bytes win over cache bytes; uncovered bytes read as zero.
    always_comb begin
        merged_data = '0;
        for (int b = 0; b < DCACHE_DATA_B_W; b++) begin
            if (stq_be_q[b]) begin
                merged_data[b*8 +: 8] = stq_data_q[b*8 +: 8];
            end else if (cache_hit_q) begin
                merged_data[b*8 +: 8] = cache_data_q[b*8 +: 8];
            end
        end
    end

    assign o_snoop_req_ready   = (state_q == IDLE);
    assign o_l1d_req_s0_valid  = l1d_req_q;
    assign o_l1d_req_s0_paddr  = paddr_q;
    assign o_stq_req_s0_valid  = stq_req_q;
    assign o_stq_req_s0_paddr  = paddr_q;
    assign o_snoop_resp_valid  = (state_q == RESP);
    assign o_snoop_resp_status = status_q;
    assign o_snoop_resp_be     = {DCACHE_DATA_B_W{cache_hit_q}} | stq_be_q;
    assign o_snoop_resp_data   = merged_data;

endmodule

// File: tb/tb_msrh_snoop_unit.sv
// Randomised bench for msrh_snoop_unit against a transaction-level reference model.
module tb_msrh_snoop_unit;
    import msrh_lsu_pkg::*;

    localparam int PADDR_W   = 56;
    localparam int DW        = 128;
    localparam int BW        = 16;
    localparam int MAX_RETRY = 3;
`ifdef MSRH_SNOOP_STQ_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic               clk, rst_n;
    logic               req_valid, req_ready;
    logic [PADDR_W-1:0] req_paddr;
    logic               l1d_s0_valid, stq_s0_valid;
    logic [PADDR_W-1:0] l1d_s0_paddr, stq_s0_paddr;
    logic               l1d_s1_valid;
    status_t            l1d_s1_status;
    logic [DW-1:0]      l1d_s1_data;
    logic               stq_s1_valid;
    logic [BW-1:0]      stq_s1_be;
    logic [DW-1:0]      stq_s1_data;
    logic               resp_valid, resp_ready;
    status_t            resp_status;
    logic [BW-1:0]      resp_be;
    logic [DW-1:0]      resp_data;

    msrh_snoop_unit dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_snoop_req_valid(req_valid), .o_snoop_req_ready(req_ready), .i_snoop_req_paddr(req_paddr),
        .o_l1d_req_s0_valid(l1d_s0_valid), .o_l1d_req_s0_paddr(l1d_s0_paddr),
        .i_l1d_resp_s1_valid(l1d_s1_valid), .i_l1d_resp_s1_status(l1d_s1_status),
        .i_l1d_resp_s1_data(l1d_s1_data),
        .o_stq_req_s0_valid(stq_s0_valid), .o_stq_req_s0_paddr(stq_s0_paddr),
        .i_stq_resp_s1_valid(stq_s1_valid), .i_stq_resp_s1_be(stq_s1_be),
        .i_stq_resp_s1_data(stq_s1_data),
        .o_snoop_resp_valid(resp_valid), .i_snoop_resp_ready(resp_ready),
        .o_snoop_resp_status(resp_status), .o_snoop_resp_be(resp_be), .o_snoop_resp_data(resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // transaction description
    logic [PADDR_W-1:0] t_paddr;
    status_t            t_st[MAX_RETRY+1];
    logic [DW-1:0]      t_l1d_data, t_stq_data;
    logic [BW-1:0]      t_stq_be;
    int                 t_stq_at, t_ready_at;
    bit                 t_stray;
    // expectations
    status_t            e_status;
    logic [BW-1:0]      e_be;
    logic [DW-1:0]      e_data;
    int                 e_n, e_resp_k, e_hs_k;
    // observations
    status_t            o_status;
    logic [BW-1:0]      o_be;
    logic [DW-1:0]      o_data;
    logic [PADDR_W-1:0] o_s0_paddr;
    int                 o_resp_k, o_hs_k, o_l1d_pulses, o_stq_pulses, o_acc_cyc;
    bit                 o_paddr_ok, o_stable_ok, o_busy_ok, o_idle_after;

    function automatic logic [DW-1:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model();
        bit found = 0;
        e_n = MAX_RETRY + 1;
        e_status = STATUS_L1D_CONFLICT;
        for (int i = 0; i <= MAX_RETRY; i++) begin
            if (!found && t_st[i] != STATUS_L1D_CONFLICT) begin
                found = 1;
                e_n = i + 1;
                e_status = t_st[i];
            end
        end
        e_data = '0;
        for (int b = 0; b < BW; b++) begin
            if (MERGE && t_stq_be[b]) e_data[b*8 +: 8] = t_stq_data[b*8 +: 8];
            else if (e_status == STATUS_HIT) e_data[b*8 +: 8] = t_l1d_data[b*8 +: 8];
        end
        e_be = (e_status == STATUS_HIT) ? {BW{1'b1}} : '0;
        if (MERGE) e_be = e_be | t_stq_be;
        e_resp_k = 1 + 2 * e_n;
        if (MERGE && t_stq_at + 1 > e_resp_k) e_resp_k = t_stq_at + 1;
        e_hs_k = (t_ready_at > e_resp_k) ? t_ready_at : e_resp_k;
    endtask

    // Called and returns at a negedge; acts as L2, L1D and STQ for one transaction.
    task automatic drive_txn();
        logic [PADDR_W-1:0] aligned;
        bit l1d_pend = 0;
        int idx = 0;
        int w = 0;
        aligned = t_paddr & ~PADDR_W'(BW - 1);
        o_resp_k = -1; o_hs_k = -1; o_l1d_pulses = 0; o_stq_pulses = 0;
        o_paddr_ok = 1; o_stable_ok = 1; o_busy_ok = 1; o_s0_paddr = '0;
        req_valid = 1'b1;
        req_paddr = t_paddr;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        o_acc_cyc = cyc;
        for (int k = 1; k < 80; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (l1d_pend) begin
                l1d_s1_valid = 1'b1;
                l1d_s1_status = t_st[idx];
                l1d_s1_data = t_l1d_data;
                if (idx < MAX_RETRY) idx++;
            end else if (t_stray && $urandom_range(0, 1) == 1) begin
                l1d_s1_valid = 1'b1;
                l1d_s1_status = status_t'($urandom_range(1, 3));
                l1d_s1_data = rnd_line();
            end else begin
                l1d_s1_valid = 1'b0;
                l1d_s1_status = STATUS_NONE;
                l1d_s1_data = '0;
            end
            if (k == t_stq_at) begin
                stq_s1_valid = 1'b1; stq_s1_be = t_stq_be; stq_s1_data = t_stq_data;
            end else if (t_stray && k > t_stq_at && $urandom_range(0, 1) == 1) begin
                stq_s1_valid = 1'b1; stq_s1_be = BW'($urandom()); stq_s1_data = rnd_line();
            end else begin
                stq_s1_valid = 1'b0; stq_s1_be = '0; stq_s1_data = '0;
            end
            resp_ready = (k >= t_ready_at);
            l1d_pend = l1d_s0_valid;
            if (l1d_s0_valid) begin
                if (o_l1d_pulses == 0) o_s0_paddr = l1d_s0_paddr;
                o_l1d_pulses++;
            end
            if (stq_s0_valid) o_stq_pulses++;
            if (!req_ready && (l1d_s0_paddr !== aligned || stq_s0_paddr !== aligned)) o_paddr_ok = 0;
            if (resp_valid) begin
                if (req_ready) o_busy_ok = 0;
                if (o_resp_k < 0) begin
                    o_resp_k = k; o_status = resp_status; o_be = resp_be; o_data = resp_data;
                end else if (resp_status !== o_status || resp_be !== o_be || resp_data !== o_data) begin
                    o_stable_ok = 0;
                end
                if (resp_ready) begin
                    o_hs_k = k;
                    break;
                end
            end
        end
        @(negedge clk);
        resp_ready = 1'b0; l1d_s1_valid = 1'b0; stq_s1_valid = 1'b0;
        o_idle_after = req_ready && !resp_valid;
    endtask

    task automatic set_plain(status_t st);
        t_paddr = {8'h00, 48'($urandom()) << 8} | PADDR_W'($urandom_range(0, 255));
        for (int i = 0; i <= MAX_RETRY; i++) t_st[i] = st;
        t_l1d_data = rnd_line(); t_stq_data = rnd_line(); t_stq_be = '0;
        t_stq_at = 2; t_ready_at = 0; t_stray = 0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || l1d_s0_valid !== 1'b0 || stq_s0_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ready=%b rv=%b l1d=%b stq=%b want 1 0 0 0",
                     req_ready, resp_valid, l1d_s0_valid, stq_s0_valid);
        end
        n_checks++;
        if (resp_be !== '0 || resp_data !== '0 || resp_status !== STATUS_NONE ||
            l1d_s0_paddr !== '0 || stq_s0_paddr !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got be=%h data=%h st=%0d pa=%h want zeros", resp_be, resp_data,
                     resp_status, l1d_s0_paddr);
        end
    endtask

    task automatic test_hit();
        set_plain(STATUS_HIT);
        t_paddr = 56'h0000_8000_0048;
        t_l1d_data = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        model(); drive_txn();
        n_checks++;
        if (o_s0_paddr !== 56'h0000_8000_0040) begin
            n_fail++; $display("FAIL hit_s0_paddr: got %h want %h", o_s0_paddr, 56'h0000_8000_0040);
        end
        n_checks++;
        if (o_resp_k !== 3) begin n_fail++; $display("FAIL hit_latency: got %0d want 3", o_resp_k); end
        n_checks++;
        if (o_status !== STATUS_HIT || o_be !== 16'hFFFF || o_data !== t_l1d_data) begin
            n_fail++; $display("FAIL hit_resp: got st=%0d be=%h data=%h want st=1 be=ffff data=%h",
                               o_status, o_be, o_data, t_l1d_data);
        end
        n_checks++;
        if (o_stq_pulses !== int'(MERGE) || !o_idle_after) begin
            n_fail++; $display("FAIL hit_stq_pulse: got %0d idle=%0d want %0d idle=1", o_stq_pulses,
                               o_idle_after, MERGE);
        end
    endtask

    task automatic test_miss_stq();
        set_plain(STATUS_MISS);
        t_stq_be = 16'h00F0;
        t_stq_data = {64'hdead_beef_0123_4567, 32'h1413_1211, 32'hcafe_f00d};
        t_stq_at = 5;
        model(); drive_txn();
        n_checks++;
        if (o_resp_k !== (MERGE ? 6 : 3)) begin
            n_fail++; $display("FAIL miss_latency: got %0d want %0d", o_resp_k, MERGE ? 6 : 3);
        end
        n_checks++;
        if (o_status !== STATUS_MISS || o_be !== e_be || o_data !== e_data) begin
            n_fail++; $display("FAIL miss_resp: got st=%0d be=%h data=%h want st=2 be=%h data=%h",
                               o_status, o_be, o_data, e_be, e_data);
        end
    endtask

    task automatic test_merge();
        set_plain(STATUS_HIT);
        t_l1d_data = {16{8'hAA}};
        t_stq_be = 16'h0001;
        t_stq_data = {rnd_line() >> 8, 8'h55} ;
        model(); drive_txn();
        n_checks++;
        if (o_be !== 16'hFFFF || o_data !== e_data) begin
            n_fail++; $display("FAIL merge_resp: got be=%h data=%h want be=ffff data=%h", o_be, o_data, e_data);
        end
    endtask

    task automatic test_conflict_retry();
        set_plain(STATUS_HIT);
        t_st[0] = STATUS_L1D_CONFLICT; t_st[1] = STATUS_L1D_CONFLICT;
        t_stq_be = 16'h0300; t_stq_at = 4;
        model(); drive_txn();
        n_checks++;
        if (o_l1d_pulses !== 3 || o_stq_pulses !== int'(MERGE)) begin
            n_fail++; $display("FAIL retry_pulses: got l1d=%0d stq=%0d want 3 %0d", o_l1d_pulses,
                               o_stq_pulses, MERGE);
        end
        n_checks++;
        if (o_status !== STATUS_HIT || o_resp_k !== 7 || o_data !== e_data || o_be !== e_be) begin
            n_fail++; $display("FAIL retry_resp: got st=%0d k=%0d be=%h want st=1 k=7 be=%h",
                               o_status, o_resp_k, o_be, e_be);
        end
    endtask

    task automatic test_conflict_exhaust();
        set_plain(STATUS_L1D_CONFLICT);
        t_stq_be = 16'hA00C; t_stq_at = 3;
        model(); drive_txn();
        n_checks++;
        if (o_l1d_pulses !== MAX_RETRY + 1 || o_resp_k !== 2 * MAX_RETRY + 3) begin
            n_fail++; $display("FAIL exhaust_timing: got pulses=%0d k=%0d want %0d %0d", o_l1d_pulses,
                               o_resp_k, MAX_RETRY + 1, 2 * MAX_RETRY + 3);
        end
        n_checks++;
        if (o_status !== STATUS_L1D_CONFLICT || o_be !== e_be || o_data !== e_data) begin
            n_fail++; $display("FAIL exhaust_resp: got st=%0d be=%h want st=3 be=%h", o_status, o_be, e_be);
        end
    endtask

    task automatic test_backpressure();
        set_plain(STATUS_HIT);
        t_stq_be = 16'h8001; t_stq_at = 2;
        model();
        t_ready_at = e_resp_k + 5;
        model(); drive_txn();
        n_checks++;
        if (!o_stable_ok || !o_busy_ok) begin
            n_fail++; $display("FAIL bp_hold: got stable=%0d busy=%0d want 1 1", o_stable_ok, o_busy_ok);
        end
        n_checks++;
        if (o_hs_k !== e_resp_k + 5 || !o_idle_after) begin
            n_fail++; $display("FAIL bp_handshake: got k=%0d idle=%0d want %0d 1", o_hs_k, o_idle_after,
                               e_resp_k + 5);
        end
    endtask

    task automatic test_back_to_back();
        int a0;
        set_plain(STATUS_HIT);
        model(); drive_txn();
        a0 = o_acc_cyc;
        set_plain(STATUS_MISS);
        model(); drive_txn();
        n_checks++;
        if (o_acc_cyc - a0 !== 4 || o_status !== STATUS_MISS) begin
            n_fail++; $display("FAIL b2b_spacing: got gap=%0d st=%0d want 4 2", o_acc_cyc - a0, o_status);
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_paddr = 56'h0000_1234_5678;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        stq_s1_valid = 1'b1; stq_s1_be = 16'hFFFF; stq_s1_data = rnd_line();
        @(negedge clk);
        stq_s1_valid = 1'b0; stq_s1_be = '0;
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got ready=%b want 0", req_ready); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || l1d_s0_valid !== 1'b0 || stq_s0_valid !== 1'b0 || req_ready !== 1'b1 ||
            resp_be !== '0 || resp_data !== '0 || resp_status !== STATUS_NONE || l1d_s0_paddr !== '0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got rv=%b l1d=%b stq=%b rdy=%b be=%h st=%0d want 0 0 0 1 0 0",
                               resp_valid, l1d_s0_valid, stq_s0_valid, req_ready, resp_be, resp_status);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_plain(STATUS_HIT);
        model(); drive_txn();
        n_checks++;
        if (o_be !== 16'hFFFF || o_data !== t_l1d_data || o_status !== STATUS_HIT) begin
            n_fail++; $display("FAIL mid_after: got be=%h data=%h want be=ffff data=%h", o_be, o_data, t_l1d_data);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            set_plain(STATUS_HIT);
            for (int i = 0; i <= MAX_RETRY; i++) begin
                case ($urandom_range(0, 3))
                    0: t_st[i] = STATUS_HIT;
                    1: t_st[i] = STATUS_MISS;
                    default: t_st[i] = STATUS_L1D_CONFLICT;
                endcase
            end
            t_stq_be = BW'($urandom());
            t_stq_at = $urandom_range(2, 10);
            t_ready_at = $urandom_range(0, 12);
            t_stray = 1'($urandom_range(0, 1));
            model(); drive_txn();
            n_checks++;
            if (o_status !== e_status || o_be !== e_be || o_data !== e_data) begin
                n_fail++; $display("FAIL rnd_resp[%0d]: got st=%0d be=%h data=%h want st=%0d be=%h data=%h",
                                   n, o_status, o_be, o_data, e_status, e_be, e_data);
            end
            n_checks++;
            if (o_resp_k !== e_resp_k || o_hs_k !== e_hs_k) begin
                n_fail++; $display("FAIL rnd_timing[%0d]: got resp=%0d hs=%0d want %0d %0d",
                                   n, o_resp_k, o_hs_k, e_resp_k, e_hs_k);
            end
            n_checks++;
            if (o_l1d_pulses !== e_n || o_stq_pulses !== int'(MERGE) || !o_paddr_ok || !o_stable_ok ||
                !o_busy_ok || !o_idle_after) begin
                n_fail++; $display("FAIL rnd_proto[%0d]: got l1d=%0d stq=%0d pa=%0d st=%0d bz=%0d idle=%0d want %0d %0d 1 1 1 1",
                                   n, o_l1d_pulses, o_stq_pulses, o_paddr_ok, o_stable_ok, o_busy_ok,
                                   o_idle_after, e_n, MERGE);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_paddr = '0; resp_ready = 1'b0;
        l1d_s1_valid = 1'b0; l1d_s1_status = STATUS_NONE; l1d_s1_data = '0;
        stq_s1_valid = 1'b0; stq_s1_be = '0; stq_s1_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_hit();
        test_miss_stq();
        test_merge();
        test_conflict_retry();
        test_conflict_exhaust();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
